// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: job sequencer for a ROWS x COLS output-stationary PE array.
// One cycle counter sets the whole schedule: the operand feed for k = 0..K-1,
// one clear per diagonal, one result-valid per diagonal, and the done pulse.
// Optional feature: define PE_CTRL_PERF_EN to add the perf_cycles output,
// which holds the cycle count of the last completed job.
module pe_array_ctrl #(
  parameter  int unsigned ROWS  = 4,
  parameter  int unsigned COLS  = 4,
  parameter  int unsigned K_MAX = 128,
  parameter  int unsigned LAT   = 2,
  localparam int unsigned ND    = ROWS + COLS - 1,
  localparam int unsigned KW    = $clog2(K_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          pe_en,
  output logic [ND-1:0] clc_diag,
  output logic          feed_vld,
  output logic [KW-1:0] feed_k,
  output logic [ND-1:0] res_vld_diag
`ifdef PE_CTRL_PERF_EN
  ,
  output logic [31:0]   perf_cycles
`endif
);

  localparam int unsigned D  = ND - 1;
  localparam int unsigned CW = $clog2(ND + LAT + K_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d;

  logic [CW-1:0] cnt_inc_c;
  logic [CW-1:0] last_c;
  logic          len_ok_c;

  // Next values of the registered outputs
  logic          busy_d, done_d, err_d, pe_en_d, feed_vld_d;
  logic [KW-1:0] feed_k_d;
  logic [ND-1:0] clc_d, res_d;
  logic [CW-1:0] last_d;

`ifdef PE_CTRL_PERF_EN
  logic [31:0]   perf_d;
`endif

  // Next-state logic, then output decode of the next state and count
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    err_d      = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    pe_en_d    = 1'b0;
    feed_vld_d = 1'b0;
    feed_k_d   = '0;
    clc_d      = '0;
    res_d      = '0;

    len_ok_c  = (k_len != '0) && (k_len <= KW'(K_MAX));
    cnt_inc_c = cnt_q + CW'(1);
    // Final cycle of the running job: last diagonal's sum completes here
    last_c    = CW'(D + LAT) + CW'(k_q);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          if (len_ok_c) begin
            state_d = S_FEED;
            k_d     = k_len;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FEED: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == last_c) begin
            state_d = S_DONE;
          end else if (cnt_inc_c == CW'(k_q)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == last_c) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs for the coming cycle, derived from the coming state and count
    last_d     = CW'(D + LAT) + CW'(k_d);
    busy_d     = (state_d != S_IDLE);
    pe_en_d    = busy_d;
    done_d     = (state_d == S_DONE);
    feed_vld_d = (state_d == S_FEED);
    feed_k_d   = feed_vld_d ? KW'(cnt_d) : '0;
    for (int unsigned d = 0; d < ND; d++) begin
      clc_d[d] = busy_d && (cnt_d == CW'(d + LAT));
      res_d[d] = busy_d && (cnt_d == (CW'(d + LAT) + CW'(k_d)));
    end

`ifdef PE_CTRL_PERF_EN
    perf_d = perf_cycles;
    if (done_d) begin
      perf_d = 32'(last_d) + 32'd1;
    end
`endif
  end

  // State, counter, latched length and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      k_q          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      pe_en        <= 1'b0;
      clc_diag     <= '0;
      feed_vld     <= 1'b0;
      feed_k       <= '0;
      res_vld_diag <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      k_q          <= k_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
      pe_en        <= pe_en_d;
      clc_diag     <= clc_d;
      feed_vld     <= feed_vld_d;
      feed_k       <= feed_k_d;
      res_vld_diag <= res_d;
    end
  end

`ifdef PE_CTRL_PERF_EN
  // Cycle count of the last job that reached done; aborted jobs leave it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
    end else begin
      perf_cycles <= perf_d;
    end
  end
`endif

endmodule

// File: doc/pe_array_ctrl.md
PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 4, PE array rows.
REQ-002 SHALL have parameter COLS, default 4, PE array columns.
REQ-003 SHALL have parameter K_MAX, default 128, maximum accumulation length (≤128 to fit PE sum width in_DW+7).
REQ-004 SHALL have parameter LAT, default 2, cycles from feed_k issue to product register at PE(0,0) (buffer read 1 + mul register 1).
REQ-005 SHALL define ND = ROWS+COLS-1 diagonals and KW = $clog2(K_MAX+1).
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, job request pulse.
REQ-009 SHALL have port k_len, input, KW, accumulation length, sampled with accepted start.
REQ-010 SHALL have port abort, input, 1, cancel running job.
REQ-011 SHALL have port busy, output, 1, job in progress.
REQ-012 SHALL have port done, output, 1, one-cycle job-complete pulse.
REQ-013 SHALL have port err, output, 1, one-cycle bad-length pulse.
REQ-014 SHALL have port pe_en, output, 1, global en to all PEs.
REQ-015 SHALL have port clc_diag, output, ND, per-diagonal clc (PE(i,j) uses bit i+j).
REQ-016 SHALL have port feed_vld, output, 1, operand buffers read this cycle.
REQ-017 SHALL have port feed_k, output, KW, k index for row 0/column 0 reads (external skew chains delay row i/col j by i/j).
REQ-018 SHALL have port res_vld_diag, output, ND, per-diagonal result-valid pulse.

Function
REQ-019 SHALL implement states IDLE, FEED, DRAIN, DONE.
REQ-020 IDLE: start=1 with 1≤k_len≤K_MAX SHALL latch k_len and enter FEED; cycle 0 = first FEED cycle.
REQ-021 IDLE: start=1 with k_len=0 or >K_MAX SHALL pulse err next cycle and stay IDLE.
REQ-022 start while busy SHALL be ignored.
REQ-023 FEED: feed_vld=1, feed_k=t for cycles t=0..K-1; then DRAIN.
REQ-024 DRAIN: feed_vld=0, feed_k=0; runs until cycle D+LAT+K, D=ND-1, then DONE.
REQ-025 clc_diag[d] SHALL be high exactly at cycle d+LAT, low otherwise.
REQ-026 res_vld_diag[d] SHALL pulse exactly at cycle d+LAT+K (PE sum for diagonal d final).
REQ-027 pe_en SHALL be 1 from cycle 0 through cycle D+LAT+K inclusive, 0 in IDLE (PE clears sums when en=0).
REQ-028 busy SHALL be 1 in FEED, DRAIN, DONE.
REQ-029 done SHALL pulse at cycle D+LAT+K (DONE state, one cycle), coincident with res_vld_diag[D]; next state IDLE.
REQ-030 K=1: clc and res_vld for a diagonal SHALL be one cycle apart; FEED lasts one cycle.
REQ-031 For K < ND, clc_diag and res_vld_diag of different diagonals SHALL overlap freely in the same cycle.
REQ-032 abort in any busy state SHALL force IDLE next cycle; all outputs 0, no done, no res_vld.
REQ-033 abort and start in same cycle while IDLE: start wins, abort ignored.
REQ-034 Single cycle counter (width ≥ $clog2(ND+LAT+K_MAX+1)) SHALL drive all timing; no wrap within a job.

Reset
REQ-035 rst=1 SHALL force IDLE and all outputs 0 on the next edge, including mid-job; latched k_len cleared.
REQ-036 rst SHALL dominate abort and start.

Configuration
REQ-037 Macro PE_CTRL_PERF_EN defined: extra output perf_cycles (32 bits) holding cycle count of last completed job (D+LAT+K+1), updated at done, cleared by rst, unchanged by aborted jobs.
REQ-038 Macro undefined: port perf_cycles and its counter SHALL not exist; all other behaviour identical.

Verification (ROWS=COLS=4, LAT=2, K_MAX=128, D=6)
REQ-039 start, k_len=8 -> feed_vld cycles 0-7, clc_diag[0]@2, clc_diag[6]@8, res_vld_diag[0]@10, res_vld_diag[6]@16, done@16, busy low @17.
REQ-040 start, k_len=0 -> err pulse next cycle, busy stays 0; k_len=129 same.
REQ-041 start, k_len=1 -> feed_vld cycle 0 only, clc_diag[3]@5, res_vld_diag[3]@6, done@9.
REQ-042 k_len=8, abort at cycle 5 -> cycle 6 all outputs 0, no done; new start accepted at cycle 6.
REQ-043 k_len=8, rst at cycle 12 -> outputs 0 cycle 13; second start during busy (cycle 3) ignored.
REQ-044 With PE_CTRL_PERF_EN, k_len=8 -> perf_cycles=17 after done.
